// File: rtl/move_sort_topk.sv
// Move-list sorter: repeated backward bubble passes over a true dual-port RAM,
// stopping early once no swap occurs or the requested top-K prefix is settled.
`ifndef MAX_POSITIONS
`define MAX_POSITIONS 256
`endif

module move_sort_topk #(
  parameter int RAM_WIDTH          = 0,
  parameter int EVAL_WIDTH         = 0,
  parameter int PRIO_BITS          = 3,
  parameter int MAX_POSITIONS_LOG2 = $clog2(`MAX_POSITIONS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sort_start,
  input  logic                          sort_clear,
  input  logic                          sort_abort,
  input  logic                          white_to_move,
  input  logic [MAX_POSITIONS_LOG2-1:0] top_k,
  input  logic                          ram_wr_addr_init,
  input  logic [RAM_WIDTH-1:0]          ram_wr_data,
  input  logic                          ram_wr,
  input  logic [MAX_POSITIONS_LOG2-1:0] ram_rd_addr,
  output logic [RAM_WIDTH-1:0]          ram_rd_data,
  output logic [MAX_POSITIONS_LOG2-1:0] ram_wr_addr,
  output logic                          sort_busy,
  output logic                          sort_complete,
  output logic [MAX_POSITIONS_LOG2-1:0] pass_count
);

  localparam int L     = MAX_POSITIONS_LOG2;
  localparam int DEPTH = 1 << L;

  typedef enum logic [3:0] {
    IDLE, PASS_INIT, READ_WS_0, READ_WS_1, COMPARE, SWAP, STEP, PASS_CHECK, DONE
  } state_t;

  state_t         state_q, state_d;
  logic [L-1:0]   n_q, n_d;
  logic [L-1:0]   k_q, k_d;
  logic [L-1:0]   pass_q, pass_d;
  logic [L-1:0]   a_q, a_d;
  logic [L-1:0]   wr_addr_q, wr_addr_d;
  logic [L-1:0]   n_minus_1;
  logic           swapped_q, swapped_d;
  logic           start_q;
  logic           busy_q, complete_q;
  logic           ext_en, start_edge, b_first;

  logic [RAM_WIDTH-1:0] mem [DEPTH];
  logic [RAM_WIDTH-1:0] rd_a_q, rd_b_q;

  logic                 we_a, we_b;
  logic [L-1:0]         addr_a, addr_b;
  logic [RAM_WIDTH-1:0] wdata_a, wdata_b;

  logic [PRIO_BITS-1:0]         flag_a, flag_b;
  logic signed [EVAL_WIDTH-1:0] eval_a, eval_b;

  // External RAM access is only granted while the sorter is parked.
  assign ext_en     = (state_q == IDLE) || (state_q == DONE);
  assign start_edge = sort_start && !start_q;
  assign n_minus_1  = wr_addr_q - L'(1);

  assign flag_a = rd_a_q[EVAL_WIDTH +: PRIO_BITS];
  assign flag_b = rd_b_q[EVAL_WIDTH +: PRIO_BITS];
  assign eval_a = rd_a_q[EVAL_WIDTH-1:0];
  assign eval_b = rd_b_q[EVAL_WIDTH-1:0];

  // Strict "b before a": flags decide first, then signed eval; equal keys stay put.
  always_comb begin
    b_first = 1'b0;
    if (flag_b != flag_a)   b_first = (flag_b > flag_a);
    else if (white_to_move) b_first = (eval_b > eval_a);
    else                    b_first = (eval_b < eval_a);
  end

  // Port A carries external writes or the lower half of the pair; port B
  // carries external reads or the upper half. A swap writes both at once.
  always_comb begin
    addr_a  = ext_en ? wr_addr_q : a_q;
    addr_b  = ext_en ? ram_rd_addr : a_q + L'(1);
    wdata_a = ext_en ? ram_wr_data : rd_b_q;
    wdata_b = rd_a_q;
    we_a    = !reset && (ext_en ? (ram_wr && !ram_wr_addr_init) : (state_q == SWAP));
    we_b    = !reset && !ext_en && (state_q == SWAP);
  end

  // NOTE: the RAM array and its read registers carry no reset; contents must survive reset.
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= wdata_a;
    if (we_b) mem[addr_b] <= wdata_b;
    rd_a_q <= mem[addr_a];
    rd_b_q <= mem[addr_b];
  end

  // NOTE: every next-state signal gets a default before the case, so no latches are inferred.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    k_d       = k_q;
    pass_d    = pass_q;
    a_d       = a_q;
    swapped_d = swapped_q;
    wr_addr_d = wr_addr_q;

    case (state_q)
      IDLE: begin
        n_d    = wr_addr_q;
        k_d    = (top_k == '0 || top_k > n_minus_1) ? n_minus_1 : top_k;
        pass_d = '0;
        if (start_edge) state_d = (wr_addr_q <= L'(1)) ? DONE : PASS_INIT;
      end
      PASS_INIT: begin
        a_d       = n_q - L'(2);
        swapped_d = 1'b0;
        state_d   = READ_WS_0;
      end
      READ_WS_0: state_d = READ_WS_1;
      READ_WS_1: state_d = COMPARE;
      COMPARE:   state_d = b_first ? SWAP : STEP;
      SWAP: begin
        swapped_d = 1'b1;
        state_d   = STEP;
      end
      STEP: begin
        if (a_q == pass_q) begin
          state_d = PASS_CHECK;
        end else begin
          a_d     = a_q - L'(1);
          state_d = READ_WS_0;
        end
      end
      PASS_CHECK: begin
        pass_d  = pass_q + L'(1);
        state_d = (!swapped_q || pass_d == k_q) ? DONE : PASS_INIT;
      end
      DONE:    if (sort_clear) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (!ext_en && sort_abort) state_d = DONE;

    if (ext_en) begin
      if (ram_wr_addr_init) wr_addr_d = '0;
      else if (ram_wr)      wr_addr_d = wr_addr_q + L'(1);
    end
  end

  // Status outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      n_q        <= '0;
      k_q        <= '0;
      pass_q     <= '0;
      a_q        <= '0;
      wr_addr_q  <= '0;
      swapped_q  <= 1'b0;
      start_q    <= sort_start;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      k_q        <= k_d;
      pass_q     <= pass_d;
      a_q        <= a_d;
      wr_addr_q  <= wr_addr_d;
      swapped_q  <= swapped_d;
      start_q    <= sort_start;
      busy_q     <= !((state_d == IDLE) || (state_d == DONE));
      complete_q <= (state_d == DONE);
    end
  end

  assign ram_rd_data   = rd_b_q;
  assign ram_wr_addr   = wr_addr_q;
  assign sort_busy     = busy_q;
  assign sort_complete = complete_q;
  assign pass_count    = pass_q;

endmodule

// File: tb/tb_move_sort_topk.sv
// Scoreboard bench for move_sort_topk: the driver queues expected observations,
// a negedge monitor pops and compares them one cycle after each request.
module tb_move_sort_topk;

  localparam int RW = 16;
  localparam int EW = 12;
  localparam int PB = 3;
  localparam int AL = 5;

  localparam int SEL_RD    = 0;
  localparam int SEL_PASS  = 1;
  localparam int SEL_CMP   = 2;
  localparam int SEL_BUSY  = 3;
  localparam int SEL_WADDR = 4;
  localparam int SEL_BCNT  = 5;
  localparam int SEL_ACC   = 6;
  localparam int SEL_SUM   = 7;
  localparam int SEL_XOR   = 8;
  localparam int SEL_CLR   = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sort_start = 1'b0;
  logic          sort_clear = 1'b0;
  logic          sort_abort = 1'b0;
  logic          white_to_move = 1'b0;
  logic [AL-1:0] top_k = '0;
  logic          ram_wr_addr_init = 1'b0;
  logic [RW-1:0] ram_wr_data = '0;
  logic          ram_wr = 1'b0;
  logic [AL-1:0] ram_rd_addr = '0;
  logic [RW-1:0] ram_rd_data;
  logic [AL-1:0] ram_wr_addr;
  logic          sort_busy;
  logic          sort_complete;
  logic [AL-1:0] pass_count;

  always #5 clk = ~clk;

  move_sort_topk #(
    .RAM_WIDTH(RW), .EVAL_WIDTH(EW), .PRIO_BITS(PB), .MAX_POSITIONS_LOG2(AL)
  ) dut (
    .clk(clk), .reset(reset), .sort_start(sort_start), .sort_clear(sort_clear),
    .sort_abort(sort_abort), .white_to_move(white_to_move), .top_k(top_k),
    .ram_wr_addr_init(ram_wr_addr_init), .ram_wr_data(ram_wr_data), .ram_wr(ram_wr),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data), .ram_wr_addr(ram_wr_addr),
    .sort_busy(sort_busy), .sort_complete(sort_complete), .pass_count(pass_count)
  );

  logic [31:0] exp_q [$];
  int          sel_q [$];
  string       name_q [$];

  logic        obs_en = 1'b0;
  logic        obs_vld = 1'b0;
  logic        cnt_clr = 1'b0;
  int          busy_cnt = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] acc_sum = '0;
  logic [31:0] acc_xor = '0;

  int          m_sel;
  logic [31:0] m_exp, m_act;
  string       m_name;

  logic [RW-1:0] vals [16];
  int            ord16 [16] = '{5, 11, 2, 7, 9, 14, 12, 0, 3, 1, 6, 8, 15, 13, 4, 10};

  always @(posedge clk) obs_vld <= obs_en;

  always @(negedge clk) begin
    if (cnt_clr)        busy_cnt <= 0;
    else if (sort_busy) busy_cnt <= busy_cnt + 1;
  end

  // Monitor: one queued observation per flagged cycle.
  always @(negedge clk) begin
    if (obs_vld) begin
      if (sel_q.size() == 0) begin
        checks   = checks + 1;
        failures = failures + 1;
        $display("FAIL scoreboard_underflow: observation with nothing expected");
      end else begin
        m_sel  = sel_q.pop_front();
        m_exp  = exp_q.pop_front();
        m_name = name_q.pop_front();
        case (m_sel)
          SEL_RD:    m_act = 32'(ram_rd_data);
          SEL_PASS:  m_act = 32'(pass_count);
          SEL_CMP:   m_act = 32'(sort_complete);
          SEL_BUSY:  m_act = 32'(sort_busy);
          SEL_WADDR: m_act = 32'(ram_wr_addr);
          SEL_BCNT:  m_act = 32'(busy_cnt);
          SEL_SUM:   m_act = acc_sum;
          SEL_XOR:   m_act = acc_xor;
          default:   m_act = '0;
        endcase
        if (m_sel == SEL_ACC) begin
          acc_sum = acc_sum + 32'(ram_rd_data);
          acc_xor = acc_xor ^ 32'(ram_rd_data);
        end else if (m_sel == SEL_CLR) begin
          acc_sum = '0;
          acc_xor = '0;
        end else begin
          checks = checks + 1;
          if (m_act !== m_exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", m_name, m_act, m_exp);
          end
        end
      end
    end
  end

  function automatic logic [RW-1:0] mk(input logic tag, input logic [PB-1:0] f, input int e);
    return {tag, f, e[EW-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    obs_en = 1'b0;
  endtask

  task automatic expect_val(input int sel, input logic [31:0] e, input string nm);
    sel_q.push_back(sel);
    exp_q.push_back(e);
    name_q.push_back(nm);
    obs_en = 1'b1;
  endtask

  task automatic check(input int sel, input logic [31:0] e, input string nm);
    expect_val(sel, e, nm);
    tick();
  endtask

  task automatic rd_chk(input int a, input logic [RW-1:0] e, input string nm);
    ram_rd_addr = AL'(a);
    check(SEL_RD, 32'(e), nm);
  endtask

  task automatic load(input int cnt);
    ram_wr_addr_init = 1'b1;
    tick();
    ram_wr_addr_init = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      ram_wr_data = vals[i];
      ram_wr      = 1'b1;
      tick();
    end
    ram_wr = 1'b0;
  endtask

  task automatic start_sort(input logic wtm, input int k, input logic hold);
    white_to_move = wtm;
    top_k         = AL'(k);
    sort_start    = 1'b1;
    tick();
    if (!hold) sort_start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 4000 && !sort_complete; i++) tick();
    check(SEL_CMP, 32'd1, nm);
  endtask

  task automatic clear_sort();
    sort_clear = 1'b1;
    tick();
    sort_clear = 1'b0;
  endtask

  task automatic load16();
    vals[0]  = mk(0, 0, 10);  vals[1]  = mk(0, 0, 3);   vals[2]  = mk(0, 2, -5);
    vals[3]  = mk(1, 0, 10);  vals[4]  = mk(0, 0, -7);  vals[5]  = mk(0, 4, 1);
    vals[6]  = mk(1, 0, 3);   vals[7]  = mk(1, 2, -5);  vals[8]  = mk(0, 0, 0);
    vals[9]  = mk(0, 1, 20);  vals[10] = mk(1, 0, -7);  vals[11] = mk(1, 4, 1);
    vals[12] = mk(0, 0, 50);  vals[13] = mk(0, 0, -2);  vals[14] = mk(0, 1, 8);
    vals[15] = mk(1, 0, 0);
    load(16);
  endtask

  initial begin
    logic [31:0] exp_sum, exp_xor;
    logic [RW-1:0] snap [16];

    tick();
    tick();
    reset = 1'b0;
    check(SEL_BUSY,  32'd0, "reset_busy");
    check(SEL_CMP,   32'd0, "reset_complete");
    check(SEL_PASS,  32'd0, "reset_pass_count");
    check(SEL_WADDR, 32'd0, "reset_wr_addr");

    // Descending full sort of 5,-3,9,0 takes three passes.
    vals[0] = mk(0, 0, 5); vals[1] = mk(0, 0, -3); vals[2] = mk(0, 0, 9); vals[3] = mk(0, 0, 0);
    load(4);
    check(SEL_WADDR, 32'd4, "wr_addr_after_4");
    start_sort(1'b1, 0, 1'b0);
    wait_done("desc_done");
    check(SEL_PASS, 32'd3, "desc_pass_count");
    rd_chk(0, mk(0, 0, 9),  "desc_idx0");
    rd_chk(1, mk(0, 0, 5),  "desc_idx1");
    rd_chk(2, mk(0, 0, 0),  "desc_idx2");
    rd_chk(3, mk(0, 0, -3), "desc_idx3");
    clear_sort();
    check(SEL_CMP, 32'd0, "clear_complete_low");

    // Ascending top-1: a single pass leaves -3,5,0,9.
    vals[0] = mk(0, 0, 5); vals[1] = mk(0, 0, -3); vals[2] = mk(0, 0, 9); vals[3] = mk(0, 0, 0);
    load(4);
    start_sort(1'b0, 1, 1'b0);
    wait_done("top1_done");
    check(SEL_PASS, 32'd1, "top1_pass_count");
    rd_chk(0, mk(0, 0, -3), "top1_idx0");
    rd_chk(1, mk(0, 0, 5),  "top1_idx1");
    rd_chk(2, mk(0, 0, 0),  "top1_idx2");
    rd_chk(3, mk(0, 0, 9),  "top1_idx3");
    clear_sort();

    // Priority flags dominate eval.
    vals[0] = mk(0, 0, 100); vals[1] = mk(0, 4, -50); vals[2] = mk(0, 2, 7);
    load(3);
    start_sort(1'b1, 0, 1'b0);
    wait_done("flags_done");
    check(SEL_PASS, 32'd2, "flags_pass_count");
    rd_chk(0, mk(0, 4, -50), "flags_idx0");
    rd_chk(1, mk(0, 2, 7),   "flags_idx1");
    rd_chk(2, mk(0, 0, 100), "flags_idx2");
    clear_sort();

    // Pre-sorted 8: one pass of 7 compares at 4 cycles, plus PASS_INIT and PASS_CHECK.
    for (int i = 0; i < 8; i++) vals[i] = mk(0, 0, 70 - 10 * i);
    load(8);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    start_sort(1'b1, 0, 1'b1);
    wait_done("presorted_done");
    check(SEL_PASS, 32'd1,  "presorted_pass_count");
    check(SEL_BCNT, 32'd30, "presorted_busy_cycles");
    rd_chk(0, mk(0, 0, 70), "presorted_idx0");
    rd_chk(7, mk(0, 0, 0),  "presorted_idx7");
    clear_sort();
    tick();
    tick();
    check(SEL_BUSY, 32'd0, "held_start_no_retrigger_busy");
    check(SEL_CMP,  32'd0, "held_start_no_retrigger_complete");
    sort_start = 1'b0;
    tick();

    // n = 0 and n = 1 finish on the cycle after the start edge.
    ram_wr_addr_init = 1'b1;
    tick();
    ram_wr_addr_init = 1'b0;
    sort_start = 1'b1;
    check(SEL_CMP, 32'd1, "n0_done_next_cycle");
    sort_start = 1'b0;
    check(SEL_PASS, 32'd0, "n0_pass_count");
    clear_sort();
    vals[0] = mk(0, 1, 33);
    load(1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    sort_start = 1'b1;
    check(SEL_CMP, 32'd1, "n1_done_next_cycle");
    sort_start = 1'b0;
    check(SEL_PASS, 32'd0, "n1_pass_count");
    check(SEL_BCNT, 32'd0, "n1_never_busy");
    rd_chk(0, mk(0, 1, 33), "n1_ram_unchanged");
    clear_sort();

    // Reset mid-pass: state clears, RAM keeps a permutation of the input.
    load16();
    exp_sum = '0;
    exp_xor = '0;
    for (int i = 0; i < 16; i++) begin
      exp_sum = exp_sum + 32'(vals[i]);
      exp_xor = exp_xor ^ 32'(vals[i]);
      snap[i] = vals[i];
    end
    start_sort(1'b1, 0, 1'b0);
    repeat (30) tick();
    check(SEL_BUSY, 32'd1, "reset_test_busy_before");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check(SEL_BUSY,  32'd0, "midreset_busy");
    check(SEL_CMP,   32'd0, "midreset_complete");
    check(SEL_PASS,  32'd0, "midreset_pass_count");
    check(SEL_WADDR, 32'd0, "midreset_wr_addr");
    check(SEL_CLR, 32'd0, "acc_clear");
    for (int i = 0; i < 16; i++) begin
      ram_rd_addr = AL'(i);
      check(SEL_ACC, 32'd0, "acc");
    end
    check(SEL_SUM, exp_sum, "midreset_multiset_sum");
    check(SEL_XOR, exp_xor, "midreset_multiset_xor");

    // Abort mid-pass, then a full stable sort of the surviving permutation.
    load16();
    start_sort(1'b1, 0, 1'b0);
    repeat (40) tick();
    check(SEL_BUSY, 32'd1, "abort_test_busy_before");
    sort_abort = 1'b1;
    check(SEL_CMP, 32'd1, "abort_done_next_cycle");
    sort_abort = 1'b0;
    check(SEL_WADDR, 32'd16, "abort_wr_addr_kept");
    clear_sort();
    start_sort(1'b1, 0, 1'b0);
    wait_done("resort_done");
    for (int i = 0; i < 16; i++) begin
      rd_chk(i, snap[ord16[i]], $sformatf("stable_idx%0d", i));
    end
    clear_sort();

    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
